// File: rtl/pipe_pkg.sv
// Fetch/decode shared types: default PC and instruction widths and the fetch-entry record.
package pipe_pkg;

  localparam int PC_W    = 12;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_queue_if.sv
// Push (fetch) and pop (decode) handshakes of the instruction queue.
// master = fetch/decode side driving the queue, slave = the queue itself.
interface instr_queue_if #(
  parameter int PC_W    = pipe_pkg::PC_W,
  parameter int INSTR_W = pipe_pkg::INSTR_W
);
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/instr_queue_mem.sv
// Queue storage: one synchronous write port, one asynchronous read port, no reset.
// Latency: write visible on read port the cycle after the edge; no backpressure of its own.
module instr_queue_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = pipe_pkg::PC_W + pipe_pkg::INSTR_W
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_queue.sv
// FWFT fetch->decode queue of DEPTH {pc, instr} entries, 1-cycle push-to-pop (0 with INSTR_QUEUE_BYPASS_EN).
// Backpressure: in_ready drops only when full (state-only, no path from out_ready); flush/rst clear occupancy.
module instr_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = pipe_pkg::PC_W,
  parameter int INSTR_W = pipe_pkg::INSTR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  instr_queue_if.slave               q,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = PC_W + INSTR_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ENT_W-1:0]   rd_data;
  logic               empty;
  logic               bypass;
  logic               push;
  logic               pop;
  logic               wr_en;
  logic [PC_W-1:0]    head_pc;
  logic [INSTR_W-1:0] head_instr;

  assign empty      = (count == '0);
  assign q.in_ready = (count != FULL_CNT);

`ifdef INSTR_QUEUE_BYPASS_EN
  assign bypass = empty && q.in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign q.out_valid = !empty || bypass;

  // A bypassed entry consumed the same cycle is never stored; otherwise it is written normally.
  assign push  = q.in_valid && q.in_ready && !(bypass && q.out_ready);
  assign pop   = q.out_valid && q.out_ready && !bypass;
  assign wr_en = push && !flush && !rst;

  always_comb begin
    head_pc    = '0;
    head_instr = '0;
    if (bypass) begin
      head_pc    = q.in_pc;
      head_instr = q.in_instr;
    end else if (!empty) begin
      {head_pc, head_instr} = rd_data;
    end
  end

  assign q.out_pc    = head_pc;
  assign q.out_instr = head_instr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  instr_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data ({q.in_pc, q.in_instr}),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_instr_queue.sv
// Directed plan steps followed by random traffic, checked against a queue-based reference model.
module tb_instr_queue;
  import pipe_pkg::*;

  localparam int DEPTH = 4;
`ifdef INSTR_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       flush;
  logic [2:0] count;
  int         n_assert = 0;
  int         n_fail   = 0;
  bit         model_ok = 0;
  fetch_entry_t model[$];

  instr_queue_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) qif ();

  instr_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .q     (qif),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst            = 1'b0;
    flush          = 1'b0;
    qif.in_valid   = 1'b0;
    qif.in_pc      = '0;
    qif.in_instr   = '0;
    qif.out_ready  = 1'b0;
  endtask

  // One clock: drive, check outputs at negedge against the model, advance model at posedge.
  task automatic cycle(input logic r, input logic f, input logic v,
                       input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] ins,
                       input logic ordy);
    bit           byp;
    bit           e_ov;
    bit           e_ir;
    fetch_entry_t e_head;
    rst = r; flush = f; qif.in_valid = v; qif.in_pc = pc; qif.in_instr = ins; qif.out_ready = ordy;
    @(negedge clk);
    byp    = BYPASS && (model.size() == 0) && v && !f;
    e_ov   = (model.size() != 0) || byp;
    e_ir   = (model.size() != DEPTH);
    e_head = '0;
    if (byp) e_head = '{pc: pc, instr: ins};
    else if (model.size() != 0) e_head = model[0];
    if (model_ok) begin
      chk("out_valid", 64'(qif.out_valid), 64'(e_ov));
      chk("in_ready",  64'(qif.in_ready),  64'(e_ir));
      chk("out_pc",    64'(qif.out_pc),    64'(e_head.pc));
      chk("out_instr", 64'(qif.out_instr), 64'(e_head.instr));
      chk("count",     64'(count),         64'(model.size()));
    end
    @(posedge clk);
    if (r || f) begin
      model.delete();
      model_ok = 1'b1;
    end else if (model_ok && !(byp && ordy)) begin
      if (e_ov && ordy) void'(model.pop_front());
      if (v && e_ir) model.push_back('{pc: pc, instr: ins});
    end
    #1 idle();
    #1;
  endtask

  initial begin
    idle();
    cycle(1, 0, 0, '0, '0, 0);
    cycle(1, 0, 0, '0, '0, 0);
    chk("rst_in_ready",  64'(qif.in_ready),  64'd1);
    chk("rst_out_valid", 64'(qif.out_valid), 64'd0);
    chk("rst_out_pc",    64'(qif.out_pc),    64'd0);
    chk("rst_out_instr", 64'(qif.out_instr), 64'd0);
    chk("rst_count",     64'(count),         64'd0);

    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, PC_W'(4 * i), $urandom(), 0);
      chk("fill_count",  64'(count),         64'(i + 1));
      chk("fill_valid",  64'(qif.out_valid), 64'd1);
      chk("fill_head",   64'(qif.out_pc),    64'h000);
    end

    cycle(0, 0, 1, 12'h00C, $urandom(), 0);
    chk("full_count", 64'(count),        64'd4);
    chk("full_ready", 64'(qif.in_ready), 64'd0);
    cycle(0, 0, 1, 12'h010, 32'h1111_0010, 0);
    chk("full_hold",  64'(count),        64'd4);
    cycle(0, 0, 1, 12'h010, 32'h1111_0010, 1);
    chk("full_pop_count", 64'(count),      64'd3);
    chk("full_pop_head",  64'(qif.out_pc), 64'h004);
    cycle(0, 0, 1, 12'h010, 32'h1111_0010, 0);
    chk("full_repush", 64'(count), 64'd4);

    cycle(0, 0, 0, '0, '0, 1);
    cycle(0, 0, 0, '0, '0, 1);
    chk("drain_count", 64'(count), 64'd2);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 1, PC_W'(12'h200 + 4 * i), $urandom(), 1);
      chk("stream_count", 64'(count), 64'd2);
    end
    chk("stream_head", 64'(qif.out_pc), 64'h220);

    cycle(0, 0, 1, 12'h300, $urandom(), 0);
    chk("pre_flush_count", 64'(count), 64'd3);
    cycle(0, 1, 1, 12'h304, $urandom(), 1);
    chk("flush_count", 64'(count),         64'd0);
    chk("flush_valid", 64'(qif.out_valid), 64'd0);
    chk("flush_pc",    64'(qif.out_pc),    64'd0);

    qif.in_valid = 1'b1; qif.in_pc = 12'h100; qif.in_instr = 32'h0050_0093; qif.out_ready = 1'b1;
    #1;
    chk("byp_same_valid", 64'(qif.out_valid), BYPASS ? 64'd1 : 64'd0);
    chk("byp_same_pc",    64'(qif.out_pc),    BYPASS ? 64'h100 : 64'd0);
    chk("byp_same_instr", 64'(qif.out_instr), BYPASS ? 64'h0050_0093 : 64'd0);
    cycle(0, 0, 1, 12'h100, 32'h0050_0093, 1);
    chk("byp_next_count", 64'(count),         BYPASS ? 64'd0 : 64'd1);
    chk("byp_next_valid", 64'(qif.out_valid), BYPASS ? 64'd0 : 64'd1);
    chk("byp_next_pc",    64'(qif.out_pc),    BYPASS ? 64'd0 : 64'h100);

    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 9) < 7), PC_W'($urandom()), $urandom(),
            ($urandom_range(0, 9) < 6));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
